// File: rtl/axis_multi_gate_controller_if.sv
// AXI4-Stream command channel for the multi-gate controller.
// Master drives tdata/tvalid, the controller returns a one-cycle tready.
interface axis_multi_gate_controller_if #(
    parameter int DATA_WIDTH = 224
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_multi_gate_controller.sv
// Multi-gate pulse controller: one timing command per stream beat.
// Optional GATE_CONTROLLER_PRELOAD_EN accepts the next command at the ending wrap.
module axis_multi_gate_controller #(
    parameter int CNTR_WIDTH  = 32,
    parameter int NUM_GATES   = 2,
    parameter int REPS_WIDTH  = 16,
    parameter int POFF_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    axis_multi_gate_controller_if.slave s_axis,
    output logic [POFF_WIDTH-1:0]      poff,
    output logic [LEVEL_WIDTH-1:0]     level,
    output logic [NUM_GATES-1:0]       dout,
    output logic                       busy,
    output logic                       period_tick
);
    localparam int TDATA_WIDTH =
        CNTR_WIDTH*(1+2*NUM_GATES)+REPS_WIDTH+POFF_WIDTH+LEVEL_WIDTH;
    localparam int REPS_LSB  = CNTR_WIDTH*(1+2*NUM_GATES);
    localparam int POFF_LSB  = REPS_LSB + REPS_WIDTH;
    localparam int LEVEL_LSB = POFF_LSB + POFF_WIDTH;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [TDATA_WIDTH-1:0]  cmd_q, cmd_d;
    logic [CNTR_WIDTH-1:0]   cntr_q, cntr_d;
    logic [REPS_WIDTH-1:0]   rep_q, rep_d;
    logic [NUM_GATES-1:0]    dout_q, dout_d;
    logic                    tready_q, tready_d;
    logic                    tick_q, tick_d;
    logic                    busy_q;

    logic [CNTR_WIDTH-1:0]   period;
    logic [REPS_WIDTH-1:0]   reps;
    logic [NUM_GATES-1:0]    start_hit;
    logic [NUM_GATES-1:0]    stop_hit;
    logic                    wrap;
    logic                    last;

    assign period = cmd_q[CNTR_WIDTH-1:0];
    assign reps   = cmd_q[REPS_LSB +: REPS_WIDTH];
    assign wrap   = (cntr_q == period);
    assign last   = (rep_q == reps);

    assign s_axis.tready = tready_q;
    assign poff          = cmd_q[POFF_LSB +: POFF_WIDTH];
    assign level         = cmd_q[LEVEL_LSB +: LEVEL_WIDTH];
    assign dout          = dout_q;
    assign busy          = busy_q;
    assign period_tick   = tick_q;

    // Per-gate start/stop compares against the running counter.
    always_comb begin
        start_hit = '0;
        stop_hit  = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            start_hit[g] = (cntr_q == cmd_q[CNTR_WIDTH*(1+2*g) +: CNTR_WIDTH]);
            stop_hit[g]  = (cntr_q == cmd_q[CNTR_WIDTH*(2+2*g) +: CNTR_WIDTH]);
        end
    end

    // Next-state logic: command accept, period counting, gate set/clear.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cntr_d   = cntr_q;
        rep_d    = rep_q;
        dout_d   = dout_q;
        tready_d = 1'b0;
        tick_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_axis.tvalid) begin
                    tready_d = 1'b1;
                    cmd_d    = s_axis.tdata;
                    cntr_d   = '0;
                    rep_d    = '0;
                    dout_d   = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    cntr_d = '0;
                    dout_d = '0;
                    tick_d = 1'b1;
                    if (last) begin
`ifdef GATE_CONTROLLER_PRELOAD_EN
                        // tready_q guard keeps a beat still in transfer from
                        // being taken twice when the command is one cycle long.
                        if (s_axis.tvalid && !tready_q) begin
                            tready_d = 1'b1;
                            cmd_d    = s_axis.tdata;
                            rep_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end else begin
                    cntr_d = cntr_q + 1'b1;
                    for (int g = 0; g < NUM_GATES; g++) begin
                        if (stop_hit[g]) begin
                            dout_d[g] = 1'b0;
                        end else if (start_hit[g]) begin
                            dout_d[g] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            cntr_q   <= '0;
            rep_q    <= '0;
            dout_q   <= '0;
            tready_q <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cntr_q   <= cntr_d;
            rep_q    <= rep_d;
            dout_q   <= dout_d;
            tready_q <= tready_d;
            tick_q   <= tick_d;
            busy_q   <= (state_d == RUN);
        end
    end
endmodule
